// File: rtl/cp0_irq.sv
// CP0 register file with edge-latched, masked, priority-encoded interrupts and ERET return.
// Optional COUNT/COMPARE timer on IP[7] when CP0_TIMER_EN is defined; 1-cycle read latency, no backpressure.
module cp0_irq #(
  parameter int          IRQ_NUM    = 4,
  parameter logic [31:0] RESET_EHBR = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         oper,
  input  logic [4:0]         addr_r,
  output logic [31:0]        data_r,
  input  logic [4:0]         addr_w,
  input  logic [31:0]        data_w,
  input  logic               ir_en,
  input  logic [IRQ_NUM-1:0] ir_in,
  input  logic [31:0]        ret_addr,
  output logic               ir,
  output logic               jump_en,
  output logic [31:0]        jump_addr
);

  localparam logic [1:0] OP_MTC0 = 2'b10;
  localparam logic [1:0] OP_ERET = 2'b11;

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_EHBR    = 5'd15;

  localparam logic [7:0] LINE_MASK = 8'((1 << IRQ_NUM) - 1);
`ifdef CP0_TIMER_EN
  localparam logic [7:0] IP_IMPL = LINE_MASK | 8'h80;
`else
  localparam logic [7:0] IP_IMPL = LINE_MASK;
`endif

  logic               ie_q, ie_d;
  logic               exl_q, exl_d;
  logic [7:0]         im_q, im_d;
  logic [7:0]         ip_q, ip_d;
  logic [4:0]         exccode_q, exccode_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        ehbr_q, ehbr_d;
  logic [IRQ_NUM-1:0] prev_q;
  logic [31:0]        data_r_q, data_r_d;

  logic       eret;
  logic       wr;
  logic [7:0] req;
  logic [2:0] take_idx;
  logic [7:0] ext_edge;
  logic [7:0] ip_set, ip_clr;

  assign eret     = (oper == OP_ERET);
  assign req      = ip_q & im_q;
  assign ir       = ir_en & ie_q & ~exl_q & (|req) & ~eret;
  // A write issued alongside a taken interrupt belongs to a flushed instruction.
  assign wr       = (oper == OP_MTC0) & ~ir;
  assign ext_edge = 8'(ir_in & ~prev_q);

  always_comb begin
    take_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) take_idx = 3'(i);
    end
  end

  assign jump_en   = ir | eret;
  assign jump_addr = ir   ? (ehbr_q + {24'b0, take_idx, 5'b0}) :
                     eret ? epc_q : 32'h0;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    if (wr && addr_w == A_COUNT)   count_d   = data_w;
    if (wr && addr_w == A_COMPARE) compare_d = data_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'h0;
      compare_q <= 32'hFFFF_FFFF;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end
`endif

  always_comb begin
    ip_set = ext_edge;
    ip_clr = (wr && addr_w == A_CAUSE) ? data_w[15:8] : 8'h0;
`ifdef CP0_TIMER_EN
    ip_set[7] = (count_q == compare_q);
    ip_clr[7] = ip_clr[7] | (wr && addr_w == A_COMPARE);
`endif
    // Set after clear so a same-cycle edge keeps the bit pending.
    ip_d = ((ip_q & ~ip_clr) | ip_set) & IP_IMPL;
  end

  always_comb begin
    ie_d      = ie_q;
    exl_d     = exl_q;
    im_d      = im_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    ehbr_d    = ehbr_q;
    if (wr) begin
      case (addr_w)
        A_STATUS: begin
          ie_d  = data_w[0];
          exl_d = data_w[1];
          im_d  = data_w[15:8];
        end
        A_EPC:   epc_d  = data_w;
        A_EHBR:  ehbr_d = {data_w[31:5], 5'b0};
        default: ;
      endcase
    end
    if (ir) begin
      epc_d     = ret_addr;
      exl_d     = 1'b1;
      exccode_d = {2'b0, take_idx};
    end else if (eret) begin
      exl_d = 1'b0;
    end
  end

  always_comb begin
    data_r_d = 32'h0;
    case (addr_r)
`ifdef CP0_TIMER_EN
      A_COUNT:   data_r_d = count_q;
      A_COMPARE: data_r_d = compare_q;
`endif
      A_STATUS:  data_r_d = {16'h0, im_q, 6'b0, exl_q, ie_q};
      A_CAUSE:   data_r_d = {16'h0, ip_q, 1'b0, exccode_q, 2'b0};
      A_EPC:     data_r_d = epc_q;
      A_EHBR:    data_r_d = ehbr_q;
      default:   data_r_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      im_q      <= 8'h0;
      ip_q      <= 8'h0;
      exccode_q <= 5'h0;
      epc_q     <= 32'h0;
      ehbr_q    <= RESET_EHBR;
      prev_q    <= '0;
      data_r_q  <= 32'h0;
    end else begin
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      im_q      <= im_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
      ehbr_q    <= ehbr_d;
      prev_q    <= ir_in;
      data_r_q  <= data_r_d;
    end
  end

  assign data_r = data_r_q;

endmodule

// File: tb/tb_cp0_irq.sv
// Directed bench for cp0_irq: reset values, interrupt take/ERET, W1C, masking, dropped MTC0, timer.
module tb_cp0_irq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  oper;
  logic [4:0]  addr_r, addr_w;
  logic [31:0] data_r, data_w;
  logic        ir_en;
  logic [3:0]  ir_in;
  logic [31:0] ret_addr;
  logic        ir, jump_en;
  logic [31:0] jump_addr;

  int checks   = 0;
  int failures = 0;

  cp0_irq #(.IRQ_NUM(4), .RESET_EHBR(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r),
    .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
    .ret_addr(ret_addr), .ir(ir), .jump_en(jump_en), .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
    addr_r = a;
    tick();
    d = data_r;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    oper = 2'b10; addr_w = a; data_w = d;
    tick();
    oper = 2'b00;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1; oper = 2'b00; addr_r = 5'd15; addr_w = 5'd0; data_w = 32'h0;
    ir_en = 1'b0; ir_in = 4'b0; ret_addr = 32'h0;
    tick(); tick();
    checks++; if (data_r !== 32'h0) begin failures++; $display("FAIL reset_data_r got=%h exp=%h", data_r, 32'h0); end
    checks++; if (ir !== 1'b0) begin failures++; $display("FAIL reset_ir got=%b exp=0", ir); end
    checks++; if (jump_en !== 1'b0) begin failures++; $display("FAIL reset_jump_en got=%b exp=0", jump_en); end
    checks++; if (jump_addr !== 32'h0) begin failures++; $display("FAIL reset_jump_addr got=%h exp=0", jump_addr); end
    rst = 1'b0;
    mfc0(5'd15, d);
    checks++; if (d !== 32'h0000_0100) begin failures++; $display("FAIL reset_ehbr got=%h exp=%h", d, 32'h100); end
    mfc0(5'd12, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
    mfc0(5'd13, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", d); end
    mfc0(5'd14, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", d); end
  endtask

  task automatic test_irq_take;
    logic [31:0] d;
    mtc0(5'd12, 32'h0000_0301);
    ir_en = 1'b1; ret_addr = 32'h40; ir_in = 4'b0011;
    #1;
    checks++; if (ir !== 1'b0) begin failures++; $display("FAIL take_before_latch got=%b exp=0", ir); end
    tick();
    ir_in = 4'b0000;
    #1;
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL take_ir got=%b exp=1", ir); end
    checks++; if (jump_en !== 1'b1) begin failures++; $display("FAIL take_jump_en got=%b exp=1", jump_en); end
    checks++; if (jump_addr !== 32'h100) begin failures++; $display("FAIL take_jump_addr got=%h exp=%h", jump_addr, 32'h100); end
    tick();
    mfc0(5'd14, d);
    checks++; if (d !== 32'h40) begin failures++; $display("FAIL take_epc got=%h exp=%h", d, 32'h40); end
    mfc0(5'd13, d);
    checks++; if (d !== 32'h300) begin failures++; $display("FAIL take_cause got=%h exp=%h", d, 32'h300); end
    mfc0(5'd12, d);
    checks++; if (d !== 32'h303) begin failures++; $display("FAIL take_status got=%h exp=%h", d, 32'h303); end
  endtask

  task automatic test_handler;
    logic [31:0] d;
    ir_in = 4'b0100;
    tick();
    ir_in = 4'b0000;
    #1;
    checks++; if (ir !== 1'b0) begin failures++; $display("FAIL handler_no_nest got=%b exp=0", ir); end
    mfc0(5'd13, d);
    checks++; if (d !== 32'h700) begin failures++; $display("FAIL handler_ip2 got=%h exp=%h", d, 32'h700); end
    ir_en = 1'b0; oper = 2'b11;
    #1;
    checks++; if (jump_en !== 1'b1) begin failures++; $display("FAIL eret_jump_en got=%b exp=1", jump_en); end
    checks++; if (jump_addr !== 32'h40) begin failures++; $display("FAIL eret_jump_addr got=%h exp=%h", jump_addr, 32'h40); end
    tick();
    oper = 2'b00;
    mfc0(5'd12, d);
    checks++; if (d !== 32'h301) begin failures++; $display("FAIL eret_status got=%h exp=%h", d, 32'h301); end
  endtask

  task automatic test_w1c;
    logic [31:0] d;
    mtc0(5'd13, 32'h100);
    mfc0(5'd13, d);
    checks++; if (d !== 32'h600) begin failures++; $display("FAIL w1c_cause got=%h exp=%h", d, 32'h600); end
    ir_en = 1'b1; ret_addr = 32'h80;
    #1;
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL w1c_ir got=%b exp=1", ir); end
    checks++; if (jump_addr !== 32'h120) begin failures++; $display("FAIL w1c_jump_addr got=%h exp=%h", jump_addr, 32'h120); end
    tick();
    mfc0(5'd13, d);
    checks++; if (d !== 32'h604) begin failures++; $display("FAIL w1c_exccode got=%h exp=%h", d, 32'h604); end
    mfc0(5'd14, d);
    checks++; if (d !== 32'h80) begin failures++; $display("FAIL w1c_epc got=%h exp=%h", d, 32'h80); end
  endtask

  task automatic test_mask;
    ir_en = 1'b0; oper = 2'b11;
    tick();
    oper = 2'b00;
    mtc0(5'd13, 32'h200);
    ir_en = 1'b1;
    #1;
    checks++; if (ir !== 1'b0) begin failures++; $display("FAIL mask_im2 got=%b exp=0", ir); end
  endtask

  task automatic test_mtc0_drop;
    logic [31:0] d;
    ir_en = 1'b0;
    mtc0(5'd12, 32'h701);
    ir_en = 1'b1; oper = 2'b10; addr_w = 5'd12; data_w = 32'h0;
    #1;
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL drop_ir got=%b exp=1", ir); end
    checks++; if (jump_addr !== 32'h140) begin failures++; $display("FAIL drop_jump_addr got=%h exp=%h", jump_addr, 32'h140); end
    tick();
    oper = 2'b00; ir_en = 1'b0;
    mfc0(5'd12, d);
    checks++; if (d !== 32'h703) begin failures++; $display("FAIL drop_status got=%h exp=%h", d, 32'h703); end
    mfc0(5'd13, d);
    checks++; if (d !== 32'h408) begin failures++; $display("FAIL drop_cause got=%h exp=%h", d, 32'h408); end
  endtask

  task automatic test_edge_wins;
    logic [31:0] d;
    ir_en = 1'b0; oper = 2'b11;
    tick();
    oper = 2'b10; addr_w = 5'd13; data_w = 32'hC00; ir_in = 4'b1000;
    tick();
    oper = 2'b00; ir_in = 4'b0000;
    mfc0(5'd13, d);
    checks++; if (d !== 32'h808) begin failures++; $display("FAIL edge_wins_cause got=%h exp=%h", d, 32'h808); end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    ir_en = 1'b0;
    mtc0(5'd15, 32'h0001_2345);
    mfc0(5'd15, d);
    checks++; if (d !== 32'h0001_2340) begin failures++; $display("FAIL ehbr_align got=%h exp=%h", d, 32'h12340); end
    mtc0(5'd3, 32'hFFFF_FFFF);
    mfc0(5'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unimpl_addr got=%h exp=0", d); end
    mtc0(5'd12, 32'hFFFF_FFFC);
    mfc0(5'd12, d);
    checks++; if (d !== 32'h0000_FF00) begin failures++; $display("FAIL status_bits got=%h exp=%h", d, 32'hFF00); end
    oper = 2'b10; addr_w = 5'd14; data_w = 32'h999; addr_r = 5'd14;
    tick();
    oper = 2'b00;
    checks++; if (data_r !== 32'h80) begin failures++; $display("FAIL rdw_old got=%h exp=%h", data_r, 32'h80); end
    tick();
    checks++; if (data_r !== 32'h999) begin failures++; $display("FAIL rdw_new got=%h exp=%h", data_r, 32'h999); end
`ifndef CP0_TIMER_EN
    mtc0(5'd11, 32'h14);
    mfc0(5'd11, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL notimer_compare got=%h exp=0", d); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    mtc0(5'd12, 32'h2);
    ir_in = 4'b0001; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    mfc0(5'd13, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rstmid_cause0 got=%h exp=0", d); end
    mfc0(5'd13, d);
    checks++; if (d !== 32'h100) begin failures++; $display("FAIL rstmid_edge got=%h exp=%h", d, 32'h100); end
    mfc0(5'd12, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rstmid_status got=%h exp=0", d); end
    mfc0(5'd14, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rstmid_epc got=%h exp=0", d); end
    mfc0(5'd15, d);
    checks++; if (d !== 32'h100) begin failures++; $display("FAIL rstmid_ehbr got=%h exp=%h", d, 32'h100); end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer;
    int k;
    ir_in = 4'b0000; ir_en = 1'b0;
    mtc0(5'd13, 32'h100);
    mtc0(5'd11, 32'd20);
    mtc0(5'd12, 32'h8001);
    mtc0(5'd9, 32'h0);
    ir_en = 1'b1;
    #1;
    k = 0;
    while (!ir && k < 40) begin
      tick();
      k++;
    end
    checks++; if (k !== 21) begin failures++; $display("FAIL timer_cycle got=%0d exp=21", k); end
    checks++; if (jump_addr !== 32'h1E0) begin failures++; $display("FAIL timer_jump_addr got=%h exp=%h", jump_addr, 32'h1E0); end
    ir_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_irq_take();
    test_handler();
    test_w1c();
    test_mask();
    test_mtc0_drop();
    test_edge_wins();
    test_regs();
    test_reset_mid();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
